// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler: default widths, FSM
// encoding and the saturating leak/integrate arithmetic.
// Optional build macro used by the block: LIF_SCHED_REFRACTORY_EN.
package lif_pkg;

    localparam int DEF_STATE_W   = 8;
    localparam int DEF_THRESHOLD = 230;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } lif_state_e;

    // Leak keeps 7/8 of v (v/2 + v/4 + v/8, each floored) and adds the input
    // current. Two guard bits hold the worst case, so the clamp never sees a
    // wrapped sum.
    function automatic logic [DEF_STATE_W-1:0] sat_leak_sum(
        input logic [DEF_STATE_W-1:0] v,
        input logic [DEF_STATE_W-1:0] c
    );
        logic [DEF_STATE_W+1:0] sum;
        sum = {2'b00, c}
            + {3'b000, v[DEF_STATE_W-1:1]}
            + {4'b0000, v[DEF_STATE_W-1:2]}
            + {5'b00000, v[DEF_STATE_W-1:3]};
        if (sum > {2'b00, {DEF_STATE_W{1'b1}}}) begin
            return {DEF_STATE_W{1'b1}};
        end else begin
            return sum[DEF_STATE_W-1:0];
        end
    endfunction

endpackage

// File: rtl/lif_update.sv
// Shared combinational LIF datapath: one neuron's next membrane value and
// spike decision. With LIF_SCHED_REFRACTORY_EN the neuron's refractory count
// is also consumed and its next value produced here.
module lif_update
    import lif_pkg::*;
#(
    parameter int STATE_W   = DEF_STATE_W,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int RC_W      = 2,
    parameter int REFRACT   = 2
) (
    input  logic [STATE_W-1:0] v_i,
    input  logic [STATE_W-1:0] c_i,
`ifdef LIF_SCHED_REFRACTORY_EN
    input  logic [RC_W-1:0]    rc_i,
    output logic [RC_W-1:0]    next_rc_o,
`endif
    output logic [STATE_W-1:0] next_v_o,
    output logic               spike_o
);

`ifdef LIF_SCHED_REFRACTORY_EN
    // Refractory neurons are clamped to zero and count down; otherwise fire or integrate.
    always_comb begin
        spike_o   = 1'b0;
        next_v_o  = {STATE_W{1'b0}};
        next_rc_o = {RC_W{1'b0}};
        if (rc_i != {RC_W{1'b0}}) begin
            next_rc_o = rc_i - RC_W'(1);
        end else if (v_i >= STATE_W'(THRESHOLD)) begin
            spike_o   = 1'b1;
            next_rc_o = RC_W'(REFRACT);
        end else begin
            next_v_o  = sat_leak_sum(v_i, c_i);
        end
    end
`else
    // Fire and reset at threshold (current ignored), otherwise leak and integrate.
    always_comb begin
        spike_o  = 1'b0;
        next_v_o = {STATE_W{1'b0}};
        if (v_i >= STATE_W'(THRESHOLD)) begin
            spike_o = 1'b1;
        end else begin
            next_v_o = sat_leak_sum(v_i, c_i);
        end
    end
`endif

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF scheduler: on tick, latches all input currents and
// sweeps the neurons one per cycle through a single lif_update instance.
// rst_n is a synchronous, active-high reset (the name is historical).
// Optional build macro: LIF_SCHED_REFRACTORY_EN adds per-neuron refractory counters.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int STATE_W   = DEF_STATE_W,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int REFRACT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         tick,
    input  logic [N_NEURONS*STATE_W-1:0] current,
    output logic                         busy,
    output logic                         done,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic                         spike_valid,
    output logic [IDX_W-1:0]             spike_idx,
    output logic                         overrun,
    input  logic [IDX_W-1:0]             state_rd_idx,
    output logic [STATE_W-1:0]           state_rd
);

    localparam int RC_W = $clog2(REFRACT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [STATE_W-1:0]    mem_q [N_NEURONS];
    logic [STATE_W-1:0]    cur_q [N_NEURONS];
    logic [N_NEURONS-1:0]  spike_vec_q;
    logic                  spike_valid_q;
    logic [IDX_W-1:0]      spike_idx_q;
    logic                  overrun_q;
    logic                  busy_q;
    logic                  done_q;
    logic [STATE_W-1:0]    upd_next_v;
    logic                  upd_spike;

`ifdef LIF_SCHED_REFRACTORY_EN
    logic [RC_W-1:0]       rc_q [N_NEURONS];
    logic [RC_W-1:0]       upd_next_rc;
`endif

    lif_update #(
        .STATE_W   (STATE_W),
        .THRESHOLD (THRESHOLD),
        .RC_W      (RC_W),
        .REFRACT   (REFRACT)
    ) u_update (
        .v_i       (mem_q[idx_q]),
        .c_i       (cur_q[idx_q]),
`ifdef LIF_SCHED_REFRACTORY_EN
        .rc_i      (rc_q[idx_q]),
        .next_rc_o (upd_next_rc),
`endif
        .next_v_o  (upd_next_v),
        .spike_o   (upd_spike)
    );

    // FSM state and sweep index register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: wait for tick, sweep every index once, one DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = UPDATE;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register file, current latches, spike reporting and status flags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i] <= {STATE_W{1'b0}};
                cur_q[i] <= {STATE_W{1'b0}};
`ifdef LIF_SCHED_REFRACTORY_EN
                rc_q[i]  <= {RC_W{1'b0}};
`endif
            end
            spike_vec_q   <= {N_NEURONS{1'b0}};
            spike_valid_q <= 1'b0;
            spike_idx_q   <= {IDX_W{1'b0}};
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            spike_valid_q <= 1'b0;
            busy_q        <= (state_d != IDLE);
            done_q        <= (state_d == DONE);
            if (tick && (state_q == IDLE)) begin
                for (int i = 0; i < N_NEURONS; i++) begin
                    cur_q[i] <= current[i*STATE_W +: STATE_W];
                end
                spike_vec_q <= {N_NEURONS{1'b0}};
            end
            if (tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (state_q == UPDATE) begin
                mem_q[idx_q] <= upd_next_v;
`ifdef LIF_SCHED_REFRACTORY_EN
                rc_q[idx_q]  <= upd_next_rc;
`endif
                if (upd_spike) begin
                    spike_vec_q[idx_q] <= 1'b1;
                    spike_valid_q      <= 1'b1;
                    spike_idx_q        <= idx_q;
                end
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_vec   = spike_vec_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign overrun     = overrun_q;
    assign state_rd    = mem_q[state_rd_idx];

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed testbench for lif_scheduler (N=4, 8-bit state, threshold 230).
module tb_lif_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [31:0] current;
    logic        busy;
    logic        done;
    logic [3:0]  spike_vec;
    logic        spike_valid;
    logic [1:0]  spike_idx;
    logic        overrun;
    logic [1:0]  state_rd_idx;
    logic [7:0]  state_rd;

    int n_tests = 0;
    int n_fail  = 0;

    lif_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .current      (current),
        .busy         (busy),
        .done         (done),
        .spike_vec    (spike_vec),
        .spike_valid  (spike_valid),
        .spike_idx    (spike_idx),
        .overrun      (overrun),
        .state_rd_idx (state_rd_idx),
        .state_rd     (state_rd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [7:0] exp);
        state_rd_idx = 2'(idx);
        #1;
        chk(tag, {24'd0, state_rd}, {24'd0, exp});
    endtask

    task automatic set_cur(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        current = {c3, c2, c1, c0};
    endtask

    // Tick once, wait (bounded) for done, count spike_valid pulses up to and
    // including the done cycle, then step into IDLE.
    task automatic do_sweep(output int nsp, output int lastidx, output int cyc);
        nsp = 0;
        lastidx = -1;
        cyc = 0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        while (done !== 1'b1 && cyc < 20) begin
            if (spike_valid === 1'b1) begin
                nsp++;
                lastidx = int'(spike_idx);
            end
            step();
            cyc++;
        end
        if (spike_valid === 1'b1) begin
            nsp++;
            lastidx = int'(spike_idx);
        end
        chk("sweep_done_seen", {31'd0, done}, 32'd1);
        step();
    endtask

    int nsp, lidx, cyc;
    logic busy_seen;

    initial begin
        rst_n = 1'b1;
        tick = 1'b0;
        current = 32'd0;
        state_rd_idx = 2'd0;

        // Reset then idle.
        step();
        step();
        rst_n = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            busy_seen = busy_seen | busy;
        end
        chk("rst_busy_never", {31'd0, busy_seen}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_spike_vec", {28'd0, spike_vec}, 32'd0);
        chk("rst_spike_valid", {31'd0, spike_valid}, 32'd0);
        chk("rst_spike_idx", {30'd0, spike_idx}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 4; i++) rd_chk("rst_state", i, 8'd0);

        // Timestep 1 with exact sweep timing: busy t+1..t+5, done only at t+5.
        set_cur(8'd100, 8'd0, 8'd0, 8'd0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("t_busy_mid", {31'd0, busy}, 32'd1);
            chk("t_done_early", {31'd0, done}, 32'd0);
            step();
        end
        chk("t_busy_t5", {31'd0, busy}, 32'd1);
        chk("t_done_t5", {31'd0, done}, 32'd1);
        step();
        chk("t_busy_t6", {31'd0, busy}, 32'd0);
        chk("t_done_t6", {31'd0, done}, 32'd0);
        rd_chk("int_ts1_n0", 0, 8'd100);
        rd_chk("int_ts1_n1", 1, 8'd0);
        rd_chk("int_ts1_n2", 2, 8'd0);
        rd_chk("int_ts1_n3", 3, 8'd0);

        // Timesteps 2..4: 100+50+25+12 = 187, then 262 -> 255, then spike.
        do_sweep(nsp, lidx, cyc);
        rd_chk("int_ts2_n0", 0, 8'd187);
        chk("int_ts2_nospike", nsp, 32'd0);
        do_sweep(nsp, lidx, cyc);
        rd_chk("int_ts3_sat", 0, 8'd255);
        chk("int_ts3_nospike", nsp, 32'd0);
        do_sweep(nsp, lidx, cyc);
        chk("int_ts4_nspike", nsp, 32'd1);
        chk("int_ts4_spike_idx", lidx, 32'd0);
        chk("int_ts4_spike_vec", {28'd0, spike_vec}, 32'd1);
        rd_chk("int_ts4_n0", 0, 8'd0);
        chk("int_overrun_clean", {31'd0, overrun}, 32'd0);

        // Overrun: ticks at t, t+2 (with changed current), t+5; clean tick at t+6.
        set_cur(8'd0, 8'd0, 8'd50, 8'd0);
        tick = 1'b1;
        step();                                    // t+1
        tick = 1'b0;
        chk("ovr_spike_vec_cleared", {28'd0, spike_vec}, 32'd0);
        step();                                    // t+2
        set_cur(8'd0, 8'd0, 8'd77, 8'd0);
        tick = 1'b1;
        chk("ovr_not_yet", {31'd0, overrun}, 32'd0);
        step();                                    // t+3
        tick = 1'b0;
        chk("ovr_set_t3", {31'd0, overrun}, 32'd1);
        step();                                    // t+4
        step();                                    // t+5
        chk("ovr_done_t5", {31'd0, done}, 32'd1);
        tick = 1'b1;
        step();                                    // t+6
        tick = 1'b0;
        chk("ovr_idle_t6", {31'd0, busy}, 32'd0);
        chk("ovr_sticky_t6", {31'd0, overrun}, 32'd1);
        rd_chk("ovr_no_relatch", 2, 8'd50);
        set_cur(8'd0, 8'd0, 8'd0, 8'd0);
        do_sweep(nsp, lidx, cyc);
        rd_chk("ovr_second_sweep", 2, 8'd43);  // 25+12+6
        chk("ovr_second_cycles", cyc, 32'd4);
        chk("ovr_sticky_end", {31'd0, overrun}, 32'd1);

        // Reset while UPDATE is at idx 2.
        set_cur(8'd10, 8'd20, 8'd30, 8'd40);
        tick = 1'b1;
        step();                                    // idx 0
        tick = 1'b0;
        step();                                    // idx 1
        step();                                    // idx 2
        rd_chk("mid_n0_written", 0, 8'd10);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_overrun_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 4; i++) rd_chk("mid_state_clr", i, 8'd0);
        busy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            busy_seen = busy_seen | done;
            step();
        end
        chk("mid_no_done", {31'd0, busy_seen}, 32'd0);
        set_cur(8'd5, 8'd6, 8'd7, 8'd8);
        do_sweep(nsp, lidx, cyc);
        chk("mid_fresh_cycles", cyc, 32'd4);
        rd_chk("mid_fresh_n0", 0, 8'd5);
        rd_chk("mid_fresh_n3", 3, 8'd8);

        // Refractory behaviour on neuron 1 with current 240.
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        set_cur(8'd0, 8'd240, 8'd0, 8'd0);
        do_sweep(nsp, lidx, cyc);
        rd_chk("ref_ts1", 1, 8'd240);
        do_sweep(nsp, lidx, cyc);
        rd_chk("ref_ts2", 1, 8'd0);
        chk("ref_ts2_spike", nsp, 32'd1);
        chk("ref_ts2_idx", lidx, 32'd1);
        chk("ref_ts2_vec", {28'd0, spike_vec}, 32'd2);
`ifdef LIF_SCHED_REFRACTORY_EN
        do_sweep(nsp, lidx, cyc);
        rd_chk("ref_ts3_hold", 1, 8'd0);
        do_sweep(nsp, lidx, cyc);
        rd_chk("ref_ts4_hold", 1, 8'd0);
        chk("ref_ts4_nospike", nsp, 32'd0);
        do_sweep(nsp, lidx, cyc);
        rd_chk("ref_ts5", 1, 8'd240);
`else
        do_sweep(nsp, lidx, cyc);
        rd_chk("noref_ts3", 1, 8'd240);
        chk("noref_ts3_vec", {28'd0, spike_vec}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
